// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the double-buffered frame store:
//   - fb_state_e : swap FSM states (FB_IDLE, FB_PENDING)
//   - FB_H_BITS / FB_V_BITS / FB_PIX_W : default raster and pixel sizes
//   - fb_addr()  : builds the linear RAM address {buffer, v, h}
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_H_BITS = 8;
    localparam int FB_V_BITS = 8;
    localparam int FB_PIX_W  = 8;

    typedef enum logic {
        FB_IDLE    = 1'b0,
        FB_PENDING = 1'b1
    } fb_state_e;

    // Unsigned concatenation {sel, v, h}. Callers cast the result down to
    // their address width; coordinates are always in range, so no masking.
    function automatic logic [31:0] fb_addr(
        input logic        sel,
        input logic [31:0] v,
        input logic [31:0] h,
        input int          h_bits,
        input int          v_bits
    );
        return (32'(sel) << (h_bits + v_bits)) | (v << h_bits) | h;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// ---------------------------------------------------------------------------
// fb_dpram
// Simple dual-port RAM: one write port, one registered read port.
// Ports:
//   clk    : clock
//   srst   : synchronous active-high reset (read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable
//   raddr  : read address
//   rdata  : read data, one cycle after re; zeroed when re=0 if RD_ZERO=1
// Array contents are never reset.
// ---------------------------------------------------------------------------
module fb_dpram #(
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter bit RD_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end else if (RD_ZERO) begin
            rdata_q <= '0;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// ---------------------------------------------------------------------------
// frame_buffer_dbl
// Double-buffered pixel frame store. The core writes into the back buffer
// while the display scans the front buffer; buffers swap only on a rising
// edge of vblank after the core has signalled a finished frame.
//
// Ports:
//   clk_sys, reset      : clock, synchronous active-high reset
//   wr_en/wr_h/wr_v/wr_data : pixel write into the back buffer
//   frame_done          : rising edge = back frame complete
//   vblank              : rising edge = swap opportunity
//   rd_en/rd_h/rd_v     : front-buffer read request
//   rd_data             : read pixel, 1-cycle latency, 0 when rd_en=0
//   front_sel           : buffer currently displayed
//   swap_pending        : finished frame waiting for vblank
//   overrun_cnt         : frames finished while already pending (saturating)
//   clr_busy            : clear engine active
//
// Build option FRAMEBUF_CLEAR_EN: every swap launches a clear engine that
// fills the new back buffer with CLEAR_VALUE, one pixel per cycle, yielding
// to core writes. Without it clr_busy is constant 0.
// ---------------------------------------------------------------------------
module frame_buffer_dbl
    import fb_pkg::*;
#(
    parameter int               H_BITS      = FB_H_BITS,
    parameter int               V_BITS      = FB_V_BITS,
    parameter int               PIX_W       = FB_PIX_W,
    parameter logic [PIX_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [H_BITS-1:0] wr_h,
    input  logic [V_BITS-1:0] wr_v,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              frame_done,
    input  logic              vblank,
    input  logic              rd_en,
    input  logic [H_BITS-1:0] rd_h,
    input  logic [V_BITS-1:0] rd_v,
    output logic [PIX_W-1:0]  rd_data,
    output logic              front_sel,
    output logic              swap_pending,
    output logic [7:0]        overrun_cnt,
    output logic              clr_busy
);

    localparam int PIX_BITS = H_BITS + V_BITS;
    localparam int ADDR_W   = PIX_BITS + 1;
    localparam int DEPTH    = 2 ** ADDR_W;

    // ---------------- edge detection ----------------
    // armed_q stays low for the first cycle after reset so that a level
    // already high at reset release is absorbed instead of seen as an edge.
    logic frame_q, frame_d;
    logic vblank_q, vblank_d;
    logic armed_q, armed_d;
    logic frame_rise, vblank_rise;

    always_comb begin
        frame_d     = frame_done;
        vblank_d    = vblank;
        armed_d     = 1'b1;
        frame_rise  = armed_q & frame_done & ~frame_q;
        vblank_rise = armed_q & vblank & ~vblank_q;
    end

    // ---------------- swap FSM ----------------
    fb_state_e  state_q, state_d;
    logic       front_sel_q, front_sel_d;
    logic [7:0] overrun_q, overrun_d;
    logic       swap;

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        overrun_d   = overrun_q;
        swap        = 1'b0;
        case (state_q)
            FB_IDLE: begin
                if (frame_rise) begin
                    if (vblank_rise) begin
                        swap = 1'b1;
                    end else begin
                        state_d = FB_PENDING;
                    end
                end
            end
            FB_PENDING: begin
                if (vblank_rise) begin
                    swap = 1'b1;
                    // A frame finishing on the swap edge waits for the next vblank.
                    state_d = frame_rise ? FB_PENDING : FB_IDLE;
                end else if (frame_rise && (overrun_q != 8'hFF)) begin
                    overrun_d = overrun_q + 8'd1;
                end
            end
            default: begin
                state_d = FB_IDLE;
            end
        endcase
        if (swap) begin
            front_sel_d = ~front_sel_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= FB_IDLE;
            front_sel_q <= 1'b0;
            overrun_q   <= 8'd0;
            frame_q     <= 1'b0;
            vblank_q    <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            overrun_q   <= overrun_d;
            frame_q     <= frame_d;
            vblank_q    <= vblank_d;
            armed_q     <= armed_d;
        end
    end

    // ---------------- address generation ----------------
    // Core writes target the back buffer as registered this cycle, so a
    // write in the swap cycle still lands in the old back buffer.
    logic [ADDR_W-1:0] core_waddr;
    logic [ADDR_W-1:0] raddr;

    always_comb begin
        core_waddr = ADDR_W'(fb_addr(~front_sel_q, 32'(wr_v), 32'(wr_h), H_BITS, V_BITS));
        raddr      = ADDR_W'(fb_addr(front_sel_q, 32'(rd_v), 32'(rd_h), H_BITS, V_BITS));
    end

    // ---------------- RAM write port mux ----------------
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [PIX_W-1:0]  mem_wdata;

`ifdef FRAMEBUF_CLEAR_EN
    logic                clr_busy_q, clr_busy_d;
    logic [PIX_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic                clr_we;

    // A swap (re)starts the sweep; a core write stalls it for that cycle.
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_cnt_d  = clr_cnt_q;
        clr_we     = 1'b0;
        if (swap) begin
            clr_busy_d = 1'b1;
            clr_cnt_d  = '0;
        end else if (clr_busy_q && !wr_en) begin
            clr_we = 1'b1;
            if (clr_cnt_q == '1) begin
                clr_busy_d = 1'b0;
                clr_cnt_d  = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + PIX_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    always_comb begin
        mem_we    = wr_en | clr_we;
        mem_waddr = wr_en ? core_waddr : {~front_sel_q, clr_cnt_q};
        mem_wdata = wr_en ? wr_data : CLEAR_VALUE;
    end

    assign clr_busy = clr_busy_q;
`else
    // Write data is a don't-care while wr_en is low.
    always_comb begin
        mem_we    = wr_en;
        mem_waddr = core_waddr;
        mem_wdata = wr_en ? wr_data : CLEAR_VALUE;
    end

    assign clr_busy = 1'b0;
`endif

    fb_dpram #(
        .DEPTH   (DEPTH),
        .WIDTH   (PIX_W),
        .ADDR_W  (ADDR_W),
        .RD_ZERO (1'b1)
    ) u_ram (
        .clk   (clk_sys),
        .srst  (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (rd_data)
    );

    assign front_sel    = front_sel_q;
    assign swap_pending = (state_q == FB_PENDING);
    assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_dbl
// Directed bench for frame_buffer_dbl with a 16x16 raster of 8-bit pixels.
// Inputs change just after the falling edge; outputs are checked at the
// following falling edge. Clear-engine steps are built only when
// FRAMEBUF_CLEAR_EN is defined.
// ---------------------------------------------------------------------------
module tb_frame_buffer_dbl;

    localparam int H = 4;
    localparam int V = 4;
    localparam int P = 8;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [H-1:0] wr_h;
    logic [V-1:0] wr_v;
    logic [P-1:0] wr_data;
    logic         frame_done;
    logic         vblank;
    logic         rd_en;
    logic [H-1:0] rd_h;
    logic [V-1:0] rd_v;
    logic [P-1:0] rd_data;
    logic         front_sel;
    logic         swap_pending;
    logic [7:0]   overrun_cnt;
    logic         clr_busy;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk_sys = ~clk_sys;

    frame_buffer_dbl #(
        .H_BITS      (H),
        .V_BITS      (V),
        .PIX_W       (P),
        .CLEAR_VALUE (8'h00)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_h         (wr_h),
        .wr_v         (wr_v),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .vblank       (vblank),
        .rd_en        (rd_en),
        .rd_h         (rd_h),
        .rd_v         (rd_v),
        .rd_data      (rd_data),
        .front_sel    (front_sel),
        .swap_pending (swap_pending),
        .overrun_cnt  (overrun_cnt),
        .clr_busy     (clr_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wr_px(input int h, input int v, input int d);
        wr_en   = 1'b1;
        wr_h    = H'(h);
        wr_v    = V'(v);
        wr_data = P'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    // Read one pixel; rd_data is checked one cycle after the request.
    task automatic rd_chk(input string tag, input int h, input int v, input int exp);
        rd_en = 1'b1;
        rd_h  = H'(h);
        rd_v  = V'(v);
        tick();
        rd_en = 1'b0;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
    endtask

    // Simultaneous frame/vblank rise: swaps at once from IDLE.
    task automatic do_swap();
        frame_done = 1'b1;
        vblank     = 1'b1;
        tick();
        frame_done = 1'b0;
        vblank     = 1'b0;
    endtask

    // Counts sampled cycles with clr_busy high; bounded. When inj_at >= 0 a
    // single core write of (h,v,d) is issued at that sample index.
    task automatic busy_len(output int cnt, input int inj_at, input int h, input int v, input int d);
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 600) begin
            if (cnt == inj_at) begin
                wr_en   = 1'b1;
                wr_h    = H'(h);
                wr_v    = V'(v);
                wr_data = P'(d);
            end else begin
                wr_en = 1'b0;
            end
            cnt++;
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_h = '0; wr_v = '0; wr_data = '0;
        frame_done = 1'b0; vblank = 1'b0; rd_en = 1'b0; rd_h = '0; rd_v = '0;
        for (int i = 0; i < 2 ** (H + V + 1); i++) dut.u_ram.mem[i] = '0;
        tick();
        tick();
        chk("rst_front_sel", 32'(front_sel), 32'd0);
        chk("rst_pending", 32'(swap_pending), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        reset = 1'b0;
        tick();

        // Write lands in buffer 1; front buffer 0 still reads 0.
        wr_px(5, 3, 8'hA5);
        rd_chk("rd_front0_before", 5, 3, 0);
        chk("front_no_swap", 32'(front_sel), 32'd0);

        // Frame rise, vblank rise 10 cycles later.
        frame_done = 1'b1;
        tick();
        chk("pending_set", 32'(swap_pending), 32'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("pending_hold", 32'(swap_pending), 32'd1);
        end
        chk("front_before_vb", 32'(front_sel), 32'd0);
        vblank = 1'b1;
        rd_en  = 1'b1;
        rd_h   = H'(5);
        rd_v   = V'(3);
        tick();
        chk("front_after_vb", 32'(front_sel), 32'd1);
        chk("pending_clear", 32'(swap_pending), 32'd0);
        chk("rd_swap_cycle_old", 32'(rd_data), 32'd0);
        vblank     = 1'b0;
        frame_done = 1'b0;
        tick();
        chk("rd_new_front", 32'(rd_data), 32'hA5);
        rd_en = 1'b0;
        tick();
        chk("rd_blank", 32'(rd_data), 32'd0);

        // Overrun counting and saturation.
        pulse_frame();
        pulse_frame();
        pulse_frame();
        chk("ovr_pending", 32'(swap_pending), 32'd1);
        chk("ovr_2", 32'(overrun_cnt), 32'd2);
        for (int i = 0; i < 252; i++) pulse_frame();
        chk("ovr_254", 32'(overrun_cnt), 32'd254);
        for (int i = 0; i < 48; i++) pulse_frame();
        chk("ovr_sat_255", 32'(overrun_cnt), 32'd255);
        chk("ovr_front", 32'(front_sel), 32'd1);

        // Reset while PENDING, with frame_done held high across release.
        reset      = 1'b1;
        frame_done = 1'b1;
        tick();
        chk("mid_rst_front", 32'(front_sel), 32'd0);
        chk("mid_rst_pending", 32'(swap_pending), 32'd0);
        chk("mid_rst_overrun", 32'(overrun_cnt), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("rel_level_no_edge", 32'(swap_pending), 32'd0);
        frame_done = 1'b0;
        tick();

        // Simultaneous rises from PENDING: swap, stay pending, no overrun.
        pulse_frame();
        chk("pend_again", 32'(swap_pending), 32'd1);
        frame_done = 1'b1;
        vblank     = 1'b1;
        tick();
        chk("sim_pend_front", 32'(front_sel), 32'd1);
        chk("sim_pend_pending", 32'(swap_pending), 32'd1);
        chk("sim_pend_overrun", 32'(overrun_cnt), 32'd0);
        frame_done = 1'b0;
        vblank     = 1'b0;
        tick();
        pulse_frame();
        chk("ovr_1", 32'(overrun_cnt), 32'd1);
        vblank = 1'b1;
        tick();
        chk("vb_swap_front", 32'(front_sel), 32'd0);
        chk("vb_swap_pending", 32'(swap_pending), 32'd0);
        vblank = 1'b0;
        tick();

        // Simultaneous rises from IDLE: immediate swap, never pending.
        do_swap();
        chk("sim_idle_front", 32'(front_sel), 32'd1);
        chk("sim_idle_pending", 32'(swap_pending), 32'd0);
        chk("sim_idle_overrun", 32'(overrun_cnt), 32'd1);
        tick();

`ifdef FRAMEBUF_CLEAR_EN
        busy_len(n, -1, 0, 0, 0);
        chk("clr_drain", 32'(clr_busy), 32'd0);
        // Back buffer is 0 now; mark a pixel there, then swap it to front.
        wr_px(2, 1, 8'h5A);
        do_swap();
        chk("clr_start", 32'(clr_busy), 32'd1);
        busy_len(n, -1, 0, 0, 0);
        chk("clr_len_256", 32'(n), 32'd256);
        rd_chk("clr_front_keeps", 2, 1, 8'h5A);
        // Swap again: the buffer holding 0x5A becomes back and is cleared.
        do_swap();
        busy_len(n, -1, 0, 0, 0);
        chk("clr_len_256_b", 32'(n), 32'd256);
        // Swap back to it; meanwhile inject one core write mid-clear.
        do_swap();
        busy_len(n, 50, 10, 0, 8'h3C);
        chk("clr_len_257", 32'(n), 32'd257);
        rd_chk("clr_cleared_px", 2, 1, 0);
        do_swap();
        rd_chk("clr_core_wr_kept", 10, 0, 8'h3C);
        rd_chk("clr_neighbour", 11, 0, 0);
`else
        do_swap();
        chk("no_clr_busy_a", 32'(clr_busy), 32'd0);
        tick();
        chk("no_clr_busy_b", 32'(clr_busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
